// File: rtl/operand_pair_stager.sv
// Pairs consecutive nibbles into mixer operands A/B, captures the mixer result
// into a small FIFO and presents it downstream; counts completed pairs.
module operand_pair_stager #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  input  logic [3:0] mix_c,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready,
  output logic [7:0] pair_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_PUSH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [3:0]       mem [DEPTH];
  logic             load_a;
  logic             load_b;
  logic             push;
  logic             pop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, operand load strobes and FIFO push/pop decisions
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    push      = 1'b0;
    pop       = out_valid && out_ready && !clr;
    case (state)
      S_A: begin
        in_ready = rst_n && !clr;
        if (in_valid && in_ready) begin
          load_a    = 1'b1;
          state_nxt = S_B;
        end
      end
      S_B: begin
        in_ready = rst_n && !clr;
        if (in_valid && in_ready) begin
          load_b    = 1'b1;
          state_nxt = S_PUSH;
        end
      end
      S_PUSH: begin
        // A full FIFO may still accept when the head leaves on the same edge
        if (!clr && ((count < CNT_W'(DEPTH)) || pop)) begin
          push      = 1'b1;
          state_nxt = S_A;
        end
      end
      default: state_nxt = S_A;
    endcase
    if (clr) begin
      state_nxt = S_A;
    end
  end

  // Operand registers hold until overwritten; clr leaves them alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= 4'h0;
      op_b <= 4'h0;
    end else begin
      if (load_a) op_a <= in_data;
      if (load_b) op_b <= in_data;
    end
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage and pair counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= 4'h0;
      end
      pair_count <= 8'h00;
    end else if (push) begin
      mem[wr_ptr] <= mix_c;
      pair_count  <= pair_count + 8'd1;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

endmodule
